// File: rtl/uart_fifo_link.sv
// uart_fifo_link: full-duplex UART with a configurable frame format
// (DATA_BITS 5..8, PARITY none/odd/even, STOP_BITS 1..2) and a configurable
// baud divisor. Each direction has its own FIFO with a valid/ready handshake.
// Every received byte carries its own parity and framing error flags.
// Ports:
//   clk, rst (async, active-low)
//   rx, tx                         serial line, both idle high
//   tx_data/tx_valid/tx_ready      TX FIFO write side
//   rx_data/rx_perr/rx_ferr/rx_valid/rx_ready   RX FIFO read side (head entry)
//   rx_overrun, err_clr            sticky drop flag and its clear
//   tx_count, rx_count             FIFO occupancies

module uart_fifo_link_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is taken.
  assign do_push = push && (!full || do_pop);
  // Head reads as zero while empty so the outputs are defined out of reset.
  assign dout    = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end
endmodule

module uart_fifo_link #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int BAUD_DIV   = 434,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  output logic                          tx,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_perr,
  output logic                          rx_ferr,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count
);
  localparam int              BW      = $clog2(BAUD_DIV);
  localparam int              NW      = $clog2(DATA_BITS);
  localparam logic [BW-1:0]   BMAX    = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]   BHALF   = BW'(BAUD_DIV / 2 - 1);
  localparam logic [NW-1:0]   LASTBIT = NW'(DATA_BITS - 1);
  localparam logic            LASTSTP = 1'(STOP_BITS - 1);
  localparam bit              HAS_PAR = (PARITY != 0);
  localparam logic            ODD     = (PARITY == 1);

  function automatic logic par_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ ODD;
  endfunction

  // ---------------- TX ----------------
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tst_t;
  tst_t                 ts, ts_n;
  logic [BW-1:0]        tbc;
  logic [NW-1:0]        tbit;
  logic                 tstop;
  logic [DATA_BITS-1:0] tsh;
  logic                 tpar, ttick, tlast, tpop;
  logic [DATA_BITS-1:0] thead;
  logic                 tfull, tempty;

  uart_fifo_link_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_txf (
    .clk(clk), .rst(rst), .push(tx_valid && tx_ready), .din(tx_data),
    .pop(tpop), .dout(thead), .count(tx_count), .full(tfull), .empty(tempty)
  );

  assign tx_ready = !tfull;
  assign ttick    = (tbc == BMAX);
  assign tlast    = (ts == T_STOP) && ttick && (tstop == LASTSTP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts    <= T_IDLE;
      tbc   <= '0;
      tbit  <= '0;
      tstop <= 1'b0;
    end else begin
      ts    <= ts_n;
      tbc   <= (ts == T_IDLE || ttick) ? '0 : tbc + BW'(1);
      tbit  <= (ts != T_DATA) ? '0 : (ttick ? tbit + NW'(1) : tbit);
      tstop <= (ts != T_STOP) ? 1'b0 : (ttick ? ~tstop : tstop);
    end
  end

  // Shift register and parity are loaded whenever a byte is popped.
  always_ff @(posedge clk) begin
    if (tpop) begin
      tsh  <= thead;
      tpar <= par_bit(thead);
    end else if (ts == T_DATA && ttick) begin
      tsh  <= tsh >> 1;
    end
  end

  always_comb begin
    ts_n = ts;
    case (ts)
      T_IDLE:  if (!tempty) ts_n = T_START;
      T_START: if (ttick) ts_n = T_DATA;
      T_DATA:  if (ttick && tbit == LASTBIT) ts_n = HAS_PAR ? T_PAR : T_STOP;
      T_PAR:   if (ttick) ts_n = T_STOP;
      T_STOP:  if (tlast) ts_n = tempty ? T_IDLE : T_START;
      default: ts_n = T_IDLE;
    endcase
  end

  // Popping on the last stop cycle makes the next start bit follow without a gap.
  always_comb begin
    tpop = !tempty && (ts == T_IDLE || tlast);
    case (ts)
      T_START: tx = 1'b0;
      T_DATA:  tx = tsh[0];
      T_PAR:   tx = tpar;
      default: tx = 1'b1;
    endcase
  end

  // ---------------- RX ----------------
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rst_t;
  rst_t                 rs, rs_n;
  logic [1:0]           rsync;
  logic                 rxs;
  logic [BW-1:0]        rbc;
  logic [NW-1:0]        rbit;
  logic                 rtick, rhalf, rsample, rpsample, rssample, rbc_clr;
  logic [DATA_BITS-1:0] rsh;
  logic                 rperr_q, rpush;
  logic [DATA_BITS+1:0] rpend;
  logic                 rfull, rempty;

  uart_fifo_link_fifo #(.W(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_rxf (
    .clk(clk), .rst(rst), .push(rpush), .din(rpend),
    .pop(rx_ready), .dout({rx_perr, rx_ferr, rx_data}),
    .count(rx_count), .full(rfull), .empty(rempty)
  );

  assign rx_valid = !rempty;
  assign rxs      = rsync[1];
  assign rtick    = (rbc == BMAX);
  assign rhalf    = (rbc == BHALF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsync      <= 2'b11;
      rs         <= R_IDLE;
      rbc        <= '0;
      rbit       <= '0;
      rpush      <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rsync      <= {rsync[0], rx};
      rs         <= rs_n;
      rbc        <= (rbc_clr || rtick) ? '0 : rbc + BW'(1);
      rbit       <= (rs != R_DATA) ? '0 : (rtick ? rbit + NW'(1) : rbit);
      rpush      <= rssample;
      // A drop in the same cycle as err_clr keeps the flag set.
      if (rpush && rfull && !rx_ready) rx_overrun <= 1'b1;
      else if (err_clr)                rx_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rs == R_IDLE) rperr_q <= 1'b0;
    else if (rpsample) rperr_q <= (^{rsh, rxs}) ^ ODD;
    if (rsample) rsh <= {rxs, rsh[DATA_BITS-1:1]};
    if (rssample) rpend <= {rperr_q, !rxs, rsh};
  end

  always_comb begin
    rs_n = rs;
    case (rs)
      R_IDLE:  if (!rxs) rs_n = R_START;
      R_START: if (rhalf) rs_n = rxs ? R_IDLE : R_DATA;
      R_DATA:  if (rtick && rbit == LASTBIT) rs_n = HAS_PAR ? R_PAR : R_STOP;
      R_PAR:   if (rtick) rs_n = R_STOP;
      R_STOP:  if (rtick) rs_n = rxs ? R_IDLE : R_WAIT;
      R_WAIT:  if (rxs) rs_n = R_IDLE;
      default: rs_n = R_IDLE;
    endcase
  end

  // Counter restarts at mid-start so every later sample lands mid-bit.
  always_comb begin
    rsample  = (rs == R_DATA) && rtick;
    rpsample = (rs == R_PAR)  && rtick;
    rssample = (rs == R_STOP) && rtick;
    rbc_clr  = (rs == R_IDLE) || (rs == R_WAIT) || (rs == R_START && rhalf);
  end
endmodule

// File: tb/tb_uart_fifo_link.sv
module tb_uart_fifo_link;
  localparam int BAUD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       drv_line = 1'b1;
  logic       a_en = 1'b0, b_loop = 1'b1;

  // Instance A: 8N1, instance B: 8E2, both BAUD_DIV=4, FIFO_DEPTH=4
  logic       a_rx, a_tx, a_tx_valid, a_tx_ready, a_rx_perr, a_rx_ferr, a_rx_valid;
  logic       a_rx_ready, a_rx_overrun, a_err_clr;
  logic [7:0] a_tx_data, a_rx_data;
  logic [2:0] a_tx_count, a_rx_count;
  logic       b_rx, b_tx, b_tx_valid, b_tx_ready, b_rx_perr, b_rx_ferr, b_rx_valid;
  logic       b_rx_ready, b_rx_overrun, b_err_clr;
  logic [7:0] b_tx_data, b_rx_data;
  logic [2:0] b_tx_count, b_rx_count;

  assign a_rx = a_en ? drv_line : 1'b1;
  assign b_rx = b_loop ? b_tx : drv_line;

  uart_fifo_link #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .BAUD_DIV(BAUD), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .rx(a_rx), .tx(a_tx), .tx_data(a_tx_data), .tx_valid(a_tx_valid),
    .tx_ready(a_tx_ready), .rx_data(a_rx_data), .rx_perr(a_rx_perr), .rx_ferr(a_rx_ferr),
    .rx_valid(a_rx_valid), .rx_ready(a_rx_ready), .rx_overrun(a_rx_overrun),
    .err_clr(a_err_clr), .tx_count(a_tx_count), .rx_count(a_rx_count));

  uart_fifo_link #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .BAUD_DIV(BAUD), .FIFO_DEPTH(4)) u_b (
    .clk(clk), .rst(rst), .rx(b_rx), .tx(b_tx), .tx_data(b_tx_data), .tx_valid(b_tx_valid),
    .tx_ready(b_tx_ready), .rx_data(b_rx_data), .rx_perr(b_rx_perr), .rx_ferr(b_rx_ferr),
    .rx_valid(b_rx_valid), .rx_ready(b_rx_ready), .rx_overrun(b_rx_overrun),
    .err_clr(b_err_clr), .tx_count(b_tx_count), .rx_count(b_rx_count));

  always #5 clk = ~clk;

  int   nchecks = 0;
  int   nerrs = 0;
  logic exp_bits[$];
  logic [7:0] sbq[$];

  typedef struct {
    logic [7:0] d;
    bit         bad_par;
    bit         bad_stop;
    logic [7:0] exp_d;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;
  vec_t vt[6];

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic par_of(input logic [7:0] d, input int par);
    return (par == 1) ? ~^d : ^d;
  endfunction

  // Reference line model: start, data LSB first, optional parity, stop bits.
  function automatic void add_frame(input logic [7:0] d, input int par, input int stops);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    if (par != 0) exp_bits.push_back(par_of(d, par));
    for (int s = 0; s < stops; s++) exp_bits.push_back(1'b1);
  endfunction

  task automatic check_line();
    for (int k = 0; k < exp_bits.size(); k++)
      for (int j = 0; j < BAUD; j++) begin
        chk("a_tx_line", a_tx, exp_bits[k]);
        cyc(1);
      end
  endtask

  task automatic send_frame(input logic [7:0] d, input int par, input bit bad_par, input bit bad_stop);
    drv_line = 1'b0; cyc(BAUD);
    for (int i = 0; i < 8; i++) begin drv_line = d[i]; cyc(BAUD); end
    if (par != 0) begin drv_line = par_of(d, par) ^ bad_par; cyc(BAUD); end
    drv_line = !bad_stop; cyc(BAUD);
    drv_line = 1'b1;
    if (bad_stop) cyc(2 * BAUD);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bb[6];
    logic [7:0] ov[5];
    logic [7:0] lb[12];
    int w;

    vt[0] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1] = '{8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    vt[2] = '{8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0};
    vt[3] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
    vt[4] = '{8'hC3, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1};
    vt[5] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b1};

    a_tx_valid = 0; a_tx_data = 0; a_rx_ready = 0; a_err_clr = 0;
    b_tx_valid = 0; b_tx_data = 0; b_rx_ready = 0; b_err_clr = 0;

    // Reset state
    cyc(3);
    chk("rst_tx", a_tx, 1);
    chk("rst_tx_ready", a_tx_ready, 1);
    chk("rst_rx_valid", a_rx_valid, 0);
    chk("rst_rx_data", a_rx_data, 0);
    chk("rst_flags", {a_rx_perr, a_rx_ferr, a_rx_overrun}, 0);
    chk("rst_counts", {a_tx_count, a_rx_count, b_tx_count, b_rx_count}, 0);
    rst = 1'b1;
    cyc(2);

    // Single 8N1 frame 0xA5 on A
    a_tx_data = 8'hA5; a_tx_valid = 1; cyc(1); a_tx_valid = 0;
    chk("tx_still_idle_1cyc", a_tx, 1);
    cyc(1);
    exp_bits.delete(); add_frame(8'hA5, 0, 1);
    check_line();
    chk("tx_idle_after_a5", a_tx, 1);
    chk("tx_count_after_a5", a_tx_count, 0);
    cyc(4);

    // Six bytes into a depth-4 FIFO while busy: backpressure and contiguous frames
    for (int i = 0; i < 6; i++) bb[i] = 8'($urandom);
    exp_bits.delete();
    for (int i = 0; i < 6; i++) add_frame(bb[i], 0, 1);
    fork
      begin
        automatic int i = 0, g = 0, maxc = 0;
        automatic bit rdy;
        while (i < 6 && g < 600) begin
          a_tx_data = bb[i]; a_tx_valid = 1; rdy = a_tx_ready;
          chk("tx_ready_vs_count", a_tx_ready, a_tx_count != 3'd4);
          if (int'(a_tx_count) > maxc) maxc = int'(a_tx_count);
          cyc(1);
          if (rdy) i++;
          g++;
        end
        a_tx_valid = 0;
        chk("tx_pushed_all", i, 6);
        chk("tx_count_peak", maxc, 4);
      end
      begin
        automatic int ww = 0;
        while (a_tx === 1'b1 && ww < 20) begin cyc(1); ww++; end
        chk("tx_b2b_start_seen", ww < 20, 1);
        check_line();
        chk("tx_idle_after_b2b", a_tx, 1);
      end
    join
    cyc(4);

    // RX overrun on A
    ov[0] = 8'h11; ov[1] = 8'h22; ov[2] = 8'h33; ov[3] = 8'h44; ov[4] = 8'h55;
    a_en = 1;
    for (int i = 0; i < 5; i++) begin
      send_frame(ov[i], 0, 0, 0);
      if (i == 3) begin
        cyc(8);
        chk("rx_count_full", a_rx_count, 4);
        chk("rx_overrun_not_yet", a_rx_overrun, 0);
      end
    end
    cyc(10);
    chk("rx_count_after_ovr", a_rx_count, 4);
    chk("rx_overrun_set", a_rx_overrun, 1);
    chk("rx_valid_ovr", a_rx_valid, 1);
    a_err_clr = 1; cyc(1); a_err_clr = 0;
    chk("rx_overrun_cleared", a_rx_overrun, 0);
    for (int i = 0; i < 4; i++) begin
      chk("rx_ovr_data", a_rx_data, ov[i]);
      chk("rx_ovr_flags", {a_rx_perr, a_rx_ferr}, 0);
      a_rx_ready = 1; cyc(1); a_rx_ready = 0;
    end
    chk("rx_empty_after_pops", {a_rx_valid, a_rx_count}, 0);
    a_en = 0;

    // Table-driven injected frames on B (8E): parity and framing errors
    b_loop = 0;
    for (int v = 0; v < 6; v++) begin
      send_frame(vt[v].d, 2, vt[v].bad_par, vt[v].bad_stop);
      w = 0;
      while (!b_rx_valid && w < 30) begin cyc(1); w++; end
      chk("vec_valid", b_rx_valid, 1);
      chk("vec_data", b_rx_data, vt[v].exp_d);
      chk("vec_perr", b_rx_perr, vt[v].exp_perr);
      chk("vec_ferr", b_rx_ferr, vt[v].exp_ferr);
      b_rx_ready = 1; cyc(1); b_rx_ready = 0;
      cyc(2);
    end
    chk("vec_rx_empty", b_rx_count, 0);

    // Loopback on B with random bytes and random consumer backpressure
    b_loop = 1;
    cyc(4);
    lb[0] = 8'h00; lb[1] = 8'hFF; lb[2] = 8'h5A;
    for (int i = 3; i < 12; i++) lb[i] = 8'($urandom);
    sbq.delete();
    fork
      begin
        automatic int i = 0, g = 0;
        automatic bit rdy, vld;
        while (i < 12 && g < 3000) begin
          vld = ($urandom_range(0, 3) != 0);
          b_tx_data = lb[i]; b_tx_valid = vld; rdy = b_tx_ready;
          cyc(1);
          if (vld && rdy) begin sbq.push_back(lb[i]); i++; end
          g++;
        end
        b_tx_valid = 0;
      end
      begin
        automatic int got = 0, g = 0;
        automatic bit rdy;
        automatic logic [7:0] e;
        while (got < 12 && g < 3000) begin
          rdy = ($urandom_range(0, 1) == 1);
          b_rx_ready = rdy;
          if (b_rx_valid && rdy) begin
            if (sbq.size() == 0) chk("loop_unexpected_byte", b_rx_data, 32'hFFFF_FFFF);
            else begin
              e = sbq.pop_front();
              chk("loop_data", b_rx_data, e);
              chk("loop_flags", {b_rx_perr, b_rx_ferr}, 0);
            end
            got++;
          end
          cyc(1);
          g++;
        end
        b_rx_ready = 0;
        chk("loop_received_all", got, 12);
      end
    join
    chk("loop_overrun", b_rx_overrun, 0);

    // Reset in the middle of frames on both directions of A
    a_en = 1;
    a_tx_data = 8'h3C; a_tx_valid = 1; cyc(1);
    a_tx_data = 8'hC3; cyc(1); a_tx_valid = 0;
    drv_line = 0; cyc(BAUD); drv_line = 1; cyc(BAUD); drv_line = 0; cyc(BAUD);
    #2 rst = 1'b0;
    #1;
    chk("midrst_tx", a_tx, 1);
    chk("midrst_counts", {a_tx_count, a_rx_count}, 0);
    chk("midrst_rx_valid", a_rx_valid, 0);
    drv_line = 1;
    cyc(2);
    rst = 1'b1;
    cyc(80);
    chk("postrst_tx", a_tx, 1);
    chk("postrst_rx", {a_rx_valid, a_rx_count}, 0);
    chk("postrst_tx_count", a_tx_count, 0);
    a_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
    $finish;
  end
endmodule
